// File: rtl/excpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : excpt_ctrl
// Brief    : Exception/trap controller. Arbitrates one pipeline event, writes
//            the CSR exception port for one cycle, then flushes the pipeline
//            and hands a redirect PC (mtvec or mepc) to fetch via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module excpt_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_fault_i,
  input  logic [DATA_WIDTH-1:0] fetch_pc_i,
  input  logic                  mem_fault_i,
  input  logic [DATA_WIDTH-1:0] mem_pc_i,
  input  logic [DATA_WIDTH-1:0] mem_addr_i,
  input  logic                  mem_is_store_i,
  input  logic                  illegal_i,
  input  logic [DATA_WIDTH-1:0] illegal_pc_i,
  input  logic [DATA_WIDTH-1:0] illegal_instr_i,
  input  logic                  mret_i,
  input  logic [DATA_WIDTH-1:0] mtvec_i,
  input  logic [DATA_WIDTH-1:0] mepc_i,
  input  logic                  redirect_ready_i,
  output logic                  excpt_we_o,
  output logic [DATA_WIDTH-1:0] excpt_mepc_o,
  output logic [DATA_WIDTH-1:0] excpt_mtval_o,
  output logic [DATA_WIDTH-1:0] excpt_mcause_o,
  output logic                  flush_o,
  output logic                  redirect_valid_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  trap_count_o
);

  // Synchronous exception cause codes (interrupt bit clear)
  localparam logic [DATA_WIDTH-1:0] CAUSE_ILLEGAL = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] CAUSE_FETCH   = DATA_WIDTH'(12);
  localparam logic [DATA_WIDTH-1:0] CAUSE_LOAD    = DATA_WIDTH'(13);
  localparam logic [DATA_WIDTH-1:0] CAUSE_STORE   = DATA_WIDTH'(15);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mepc_q, mtval_q, cause_q, target_q;
  logic [CNT_WIDTH-1:0]    count_q;

  logic                    any_fault;
  logic [DATA_WIDTH-1:0]   sel_mepc, sel_mtval, sel_cause;

  assign any_fault = mem_fault_i | illegal_i | fetch_fault_i;

  // Fault arbitration: oldest instruction (mem stage) wins, then decode, then fetch
  always_comb begin
    sel_mepc  = '0;
    sel_mtval = '0;
    sel_cause = '0;
    if (mem_fault_i) begin
      sel_mepc  = mem_pc_i;
      sel_mtval = mem_addr_i;
      sel_cause = mem_is_store_i ? CAUSE_STORE : CAUSE_LOAD;
    end else if (illegal_i) begin
      sel_mepc  = illegal_pc_i;
      sel_mtval = illegal_instr_i;
      sel_cause = CAUSE_ILLEGAL;
    end else if (fetch_fault_i) begin
      sel_mepc  = fetch_pc_i;
      sel_mtval = fetch_pc_i;
      sel_cause = CAUSE_FETCH;
    end
  end

  // Next-state logic; events are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_fault)   state_d = COMMIT;
        else if (mret_i) state_d = REDIRECT;
      end
      COMMIT:   state_d = REDIRECT;
      REDIRECT: if (redirect_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Captured trap info, redirect target and saturating trap counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mepc_q   <= '0;
      mtval_q  <= '0;
      cause_q  <= '0;
      target_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_fault) begin
            mepc_q  <= sel_mepc;
            mtval_q <= sel_mtval;
            cause_q <= sel_cause;
          end else if (mret_i) begin
            target_q <= mepc_i;
          end
        end
        COMMIT: begin
          target_q <= mtvec_i;
          if (count_q != '1) count_q <= count_q + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign excpt_we_o       = (state_q == COMMIT);
  assign excpt_mepc_o     = mepc_q;
  assign excpt_mtval_o    = mtval_q;
  assign excpt_mcause_o   = cause_q;
  assign flush_o          = (state_q != IDLE);
  assign redirect_valid_o = (state_q == REDIRECT);
  assign redirect_pc_o    = target_q;
  assign busy_o           = (state_q != IDLE);
  assign trap_count_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_excpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_excpt_ctrl
// Brief    : Directed self-checking bench for excpt_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_excpt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_fault = 1'b0, mem_fault = 1'b0, mem_is_store = 1'b0;
  logic        illegal = 1'b0, mret = 1'b0, ready = 1'b0;
  logic [31:0] fetch_pc = '0, mem_pc = '0, mem_addr = '0, illegal_pc = '0;
  logic [31:0] illegal_instr = '0, mtvec = 32'h800, mepc_in = '0;

  logic        we, flush, rvalid, busy;
  logic [31:0] mepc, mtval, mcause, rpc;
  logic [15:0] count;

  logic        we2, flush2, rvalid2, busy2;
  logic [31:0] mepc2, mtval2, mcause2, rpc2;
  logic [1:0]  count2;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  excpt_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .fetch_fault_i(fetch_fault), .fetch_pc_i(fetch_pc),
    .mem_fault_i(mem_fault), .mem_pc_i(mem_pc), .mem_addr_i(mem_addr),
    .mem_is_store_i(mem_is_store),
    .illegal_i(illegal), .illegal_pc_i(illegal_pc), .illegal_instr_i(illegal_instr),
    .mret_i(mret), .mtvec_i(mtvec), .mepc_i(mepc_in), .redirect_ready_i(ready),
    .excpt_we_o(we), .excpt_mepc_o(mepc), .excpt_mtval_o(mtval),
    .excpt_mcause_o(mcause), .flush_o(flush), .redirect_valid_o(rvalid),
    .redirect_pc_o(rpc), .busy_o(busy), .trap_count_o(count)
  );

  excpt_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_n),
    .fetch_fault_i(fetch_fault), .fetch_pc_i(fetch_pc),
    .mem_fault_i(mem_fault), .mem_pc_i(mem_pc), .mem_addr_i(mem_addr),
    .mem_is_store_i(mem_is_store),
    .illegal_i(illegal), .illegal_pc_i(illegal_pc), .illegal_instr_i(illegal_instr),
    .mret_i(mret), .mtvec_i(mtvec), .mepc_i(mepc_in), .redirect_ready_i(ready),
    .excpt_we_o(we2), .excpt_mepc_o(mepc2), .excpt_mtval_o(mtval2),
    .excpt_mcause_o(mcause2), .flush_o(flush2), .redirect_valid_o(rvalid2),
    .redirect_pc_o(rpc2), .busy_o(busy2), .trap_count_o(count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events;
    fetch_fault = 1'b0; mem_fault = 1'b0; illegal = 1'b0; mret = 1'b0;
  endtask

  // Events already driven; walks COMMIT, REDIRECT and an immediate handshake
  task automatic take_fault(input string tag, input logic [31:0] e_mepc,
                            input logic [31:0] e_mtval, input logic [31:0] e_cause);
    tick;
    clear_events;
    check({tag, ".we"},     {31'b0, we},     32'd1);
    check({tag, ".mepc"},   mepc,            e_mepc);
    check({tag, ".mtval"},  mtval,           e_mtval);
    check({tag, ".cause"},  mcause,          e_cause);
    check({tag, ".flush"},  {31'b0, flush},  32'd1);
    check({tag, ".rv_c"},   {31'b0, rvalid}, 32'd0);
    exp_count++;
    tick;
    check({tag, ".we_off"}, {31'b0, we},     32'd0);
    check({tag, ".rvalid"}, {31'b0, rvalid}, 32'd1);
    check({tag, ".rpc"},    rpc,             mtvec);
    check({tag, ".count"},  {16'b0, count},  exp_count);
    ready = 1'b1;
    tick;
    ready = 1'b0;
    check({tag, ".idle"},   {31'b0, busy},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst.we",     {31'b0, we},     32'd0);
    check("rst.busy",   {31'b0, busy},   32'd0);
    check("rst.flush",  {31'b0, flush},  32'd0);
    check("rst.rvalid", {31'b0, rvalid}, 32'd0);
    check("rst.rpc",    rpc,             32'd0);
    check("rst.mepc",   mepc,            32'd0);
    check("rst.count",  {16'b0, count},  32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // Fetch fault
    fetch_fault = 1'b1; fetch_pc = 32'h100;
    take_fault("fetch", 32'h100, 32'h100, 32'd12);

    // Store fault beats simultaneous fetch fault
    mem_fault = 1'b1; mem_is_store = 1'b1; mem_pc = 32'h204; mem_addr = 32'h3F000;
    fetch_fault = 1'b1; fetch_pc = 32'h999;
    take_fault("store", 32'h204, 32'h3F000, 32'd15);
    check("store.no_retrig", {31'b0, we}, 32'd0);

    // Load fault
    mem_fault = 1'b1; mem_is_store = 1'b0; mem_pc = 32'h300; mem_addr = 32'h1234;
    take_fault("load", 32'h300, 32'h1234, 32'd13);

    // Illegal beats fetch fault
    illegal = 1'b1; illegal_pc = 32'h40; illegal_instr = 32'hDEADBEEF;
    fetch_fault = 1'b1; fetch_pc = 32'h44;
    take_fault("illegal", 32'h40, 32'hDEADBEEF, 32'd2);

    // Fault + mret same cycle: fault wins
    fetch_fault = 1'b1; fetch_pc = 32'h500; mret = 1'b1; mepc_in = 32'h777;
    take_fault("fault_mret", 32'h500, 32'h500, 32'd12);

    // mret alone: no CSR write, redirect next cycle to mepc
    mret = 1'b1; mepc_in = 32'h104;
    tick;
    clear_events;
    check("mret.we",     {31'b0, we},     32'd0);
    check("mret.rvalid", {31'b0, rvalid}, 32'd1);
    check("mret.rpc",    rpc,             32'h104);
    check("mret.flush",  {31'b0, flush},  32'd1);
    check("mret.count",  {16'b0, count},  exp_count);
    ready = 1'b1;
    tick;
    ready = 1'b0;
    check("mret.idle",   {31'b0, busy},   32'd0);

    // Redirect held while ready low; illegal pulse during wait ignored
    fetch_fault = 1'b1; fetch_pc = 32'h600;
    tick;
    clear_events;
    exp_count++;
    tick;
    for (int i = 0; i < 5; i++) begin
      check("wait.rvalid", {31'b0, rvalid}, 32'd1);
      check("wait.rpc",    rpc,             32'h800);
      check("wait.flush",  {31'b0, flush},  32'd1);
      check("wait.we",     {31'b0, we},     32'd0);
      illegal = (i == 2); illegal_pc = 32'hAA; illegal_instr = 32'hBB;
      tick;
    end
    illegal = 1'b0;
    check("wait.count", {16'b0, count}, exp_count);
    check("wait.mepc",  mepc,           32'h600);
    ready = 1'b1;
    tick;
    ready = 1'b0;
    check("wait.idle",   {31'b0, busy},   32'd0);
    check("wait.rv_off", {31'b0, rvalid}, 32'd0);
    tick;
    check("wait.no_late", {31'b0, we}, 32'd0);

    // Reset during COMMIT
    fetch_fault = 1'b1; fetch_pc = 32'h700;
    tick;
    clear_events;
    #2 rst_n = 1'b0;
    #1;
    exp_count = 0;
    check("rstc.we",    {31'b0, we},    32'd0);
    check("rstc.flush", {31'b0, flush}, 32'd0);
    check("rstc.mepc",  mepc,           32'd0);
    check("rstc.count", {16'b0, count}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    check("rstc.stay_idle", {31'b0, busy}, 32'd0);
    illegal = 1'b1; illegal_pc = 32'h80; illegal_instr = 32'h1111;
    take_fault("after_rst", 32'h80, 32'h1111, 32'd2);

    // Reset during REDIRECT
    fetch_fault = 1'b1; fetch_pc = 32'h900;
    tick;
    clear_events;
    tick;
    #2 rst_n = 1'b0;
    #1;
    exp_count = 0;
    check("rstr.rvalid", {31'b0, rvalid}, 32'd0);
    check("rstr.rpc",    rpc,             32'd0);
    check("rstr.busy",   {31'b0, busy},   32'd0);
    check("rstr.count",  {16'b0, count},  32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // Saturation: five traps, 2-bit counter holds at 3
    for (int i = 0; i < 5; i++) begin
      fetch_fault = 1'b1; fetch_pc = 32'h1000 + 32'(i * 4);
      take_fault("sat", 32'h1000 + 32'(i * 4), 32'h1000 + 32'(i * 4), 32'd12);
    end
    check("sat.count16", {16'b0, count}, 32'd5);
    check("sat.count2",  {30'b0, count2}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
